// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch-stage and a memory-stage request onto one
// shared single-port memory. Data requests win over instruction requests when
// both are pending in IDLE. Each access waits for mem_ready, or is aborted
// after TIMEOUT access cycles, which sets the sticky bus_err flag.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   inst_req/inst_addr       fetch request (held until inst_valid)
//   data_req/data_wr/
//   data_addr/data_wdata     memory-stage request (held until data_valid)
//   mem_rdata/mem_ready      memory read data and completion strobe
//   mem_req/mem_wr/
//   mem_addr/mem_wdata       memory request towards the shared memory
//   inst_rdata/data_rdata    registered read results
//   inst_valid/data_valid    one-cycle completion pulses
//   stall_if/stall_mem       pipeline stall requests
//   bus_err                  sticky timeout flag
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] inst_rdata,
  output logic [31:0] data_rdata,
  output logic        inst_valid,
  output logic        data_valid,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, IACC, DACC, DONE} state_e;

  localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);

  state_e      state_q;
  logic [4:0]  wait_q;
  logic        mem_req_q;
  logic        mem_wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] inst_rdata_q;
  logic [31:0] data_rdata_q;
  logic        inst_valid_q;
  logic        data_valid_q;
  logic        bus_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_req) begin
            addr_q    <= data_addr;
            wdata_q   <= data_wdata;
            mem_wr_q  <= data_wr;
            mem_req_q <= 1'b1;
            wait_q    <= '0;
            state_q   <= DACC;
          end else if (inst_req) begin
            addr_q    <= inst_addr;
            mem_wr_q  <= 1'b0;
            mem_req_q <= 1'b1;
            wait_q    <= '0;
            state_q   <= IACC;
          end
        end
        IACC, DACC: begin
          // Completion and timeout share the exit path; mem_wr_q still holds
          // the read/write kind of the access here, it is cleared on exit.
          if (mem_ready || wait_q == WAIT_LAST) begin
            if (!mem_ready) begin
              bus_err_q <= 1'b1;
            end
            if (state_q == IACC) begin
              inst_rdata_q <= mem_ready ? mem_rdata : '0;
              inst_valid_q <= 1'b1;
            end else begin
              if (!mem_wr_q) begin
                data_rdata_q <= mem_ready ? mem_rdata : '0;
              end
              data_valid_q <= 1'b1;
            end
            mem_req_q <= 1'b0;
            mem_wr_q  <= 1'b0;
            state_q   <= DONE;
          end else begin
            wait_q <= wait_q + 5'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign inst_valid = inst_valid_q;
  assign data_valid = data_valid_q;
  assign bus_err    = bus_err_q;
  assign stall_if   = inst_req & ~inst_valid_q;
  assign stall_mem  = data_req & ~data_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] inst_rdata;
  logic [31:0] data_rdata;
  logic        inst_valid;
  logic        data_valid;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_req  (inst_req),
    .inst_addr (inst_addr),
    .data_req  (data_req),
    .data_wr   (data_wr),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .inst_rdata(inst_rdata),
    .data_rdata(data_rdata),
    .inst_valid(inst_valid),
    .data_valid(data_valid),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the memory, how many access cycles it
  // has used, and which requester is due a completion pulse this cycle.
  int unsigned m_owner;   // 0 none, 1 instruction, 2 data
  int unsigned m_cycles;  // access cycles used by the current access
  int unsigned m_fin;     // requester completing (pulse) this cycle
  logic        m_wr;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  logic        m_err;
  logic        m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = 0; m_cycles = 0; m_fin = 0; m_wr = 1'b0;
      m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0; m_err = 1'b0;
      m_live = 1'b1;
    end else if (m_fin != 0) begin
      m_fin = 0;
    end else if (m_owner != 0) begin
      if (mem_ready) begin
        if (m_owner == 1) m_irdata = mem_rdata;
        else if (!m_wr) m_drdata = mem_rdata;
        m_fin = m_owner; m_owner = 0;
      end else if (m_cycles == TIMEOUT) begin
        m_err = 1'b1;
        if (m_owner == 1) m_irdata = '0;
        else if (!m_wr) m_drdata = '0;
        m_fin = m_owner; m_owner = 0;
      end else begin
        m_cycles++;
      end
    end else if (data_req) begin
      m_owner = 2; m_cycles = 1; m_wr = data_wr;
      m_addr = data_addr; m_wdata = data_wdata;
    end else if (inst_req) begin
      m_owner = 1; m_cycles = 1; m_wr = 1'b0; m_addr = inst_addr;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("mem_req", {31'd0, mem_req}, {31'd0, m_owner != 0});
      check("mem_wr", {31'd0, mem_wr}, {31'd0, (m_owner == 2) && m_wr});
      if (m_owner != 0) check("mem_addr", mem_addr, m_addr);
      if (m_owner == 2 && m_wr) check("mem_wdata", mem_wdata, m_wdata);
      check("inst_valid", {31'd0, inst_valid}, {31'd0, m_fin == 1});
      check("data_valid", {31'd0, data_valid}, {31'd0, m_fin == 2});
      check("inst_rdata", inst_rdata, m_irdata);
      check("data_rdata", data_rdata, m_drdata);
      check("bus_err", {31'd0, bus_err}, {31'd0, m_err});
      check("stall_if", {31'd0, stall_if}, {31'd0, inst_req && (m_fin != 1)});
      check("stall_mem", {31'd0, stall_mem}, {31'd0, data_req && (m_fin != 2)});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wr = 1'b0;
    data_addr = '0; data_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    cyc(); smp();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    cyc(); rst = 1'b0;

    // Single fetch, memory ready in the first access cycle.
    cyc(); inst_req = 1'b1; inst_addr = 32'h0000_0040; smp();
    check("f_stall0", {31'd0, stall_if}, 32'd1);
    check("f_req0", {31'd0, mem_req}, 32'd0);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'h8C01_0004; smp();
    check("f_req1", {31'd0, mem_req}, 32'd1);
    check("f_addr1", mem_addr, 32'h0000_0040);
    check("f_stall1", {31'd0, stall_if}, 32'd1);
    cyc(); mem_ready = 1'b0; mem_rdata = '0; smp();
    check("f_valid2", {31'd0, inst_valid}, 32'd1);
    check("f_rdata2", inst_rdata, 32'h8C01_0004);
    check("f_stall2", {31'd0, stall_if}, 32'd0);
    cyc(); inst_req = 1'b0; smp();
    check("f_valid3", {31'd0, inst_valid}, 32'd0);

    // Simultaneous requests: data first, then fetch.
    cyc(); inst_req = 1'b1; inst_addr = 32'h0000_0080;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0100; smp();
    check("b_stall_mem0", {31'd0, stall_mem}, 32'd1);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'h1111_2222; smp();
    check("b_addr1", mem_addr, 32'h0000_0100);
    cyc(); mem_ready = 1'b0; smp();
    check("b_dvalid2", {31'd0, data_valid}, 32'd1);
    check("b_drdata2", data_rdata, 32'h1111_2222);
    check("b_stall_if2", {31'd0, stall_if}, 32'd1);
    cyc(); data_req = 1'b0; smp();
    check("b_req3", {31'd0, mem_req}, 32'd0);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'h2222_3333; smp();
    check("b_req4", {31'd0, mem_req}, 32'd1);
    check("b_addr4", mem_addr, 32'h0000_0080);
    cyc(); mem_ready = 1'b0; smp();
    check("b_ivalid5", {31'd0, inst_valid}, 32'd1);
    check("b_irdata5", inst_rdata, 32'h2222_3333);
    cyc(); inst_req = 1'b0;

    // Data write with three wait cycles.
    cyc(); data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_0200;
    data_wdata = 32'hDEAD_BEEF; smp();
    for (int i = 1; i <= 4; i++) begin
      cyc(); mem_ready = (i == 4); mem_rdata = 32'h5555_5555; smp();
      check("w_wr", {31'd0, mem_wr}, 32'd1);
      check("w_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("w_dvalid", {31'd0, data_valid}, 32'd0);
    end
    cyc(); mem_ready = 1'b0; smp();
    check("w_dvalid5", {31'd0, data_valid}, 32'd1);
    check("w_drdata5", data_rdata, 32'h1111_2222);
    check("w_wr5", {31'd0, mem_wr}, 32'd0);
    cyc(); data_req = 1'b0; data_wr = 1'b0;

    // Request dropped mid-access still completes.
    cyc(); inst_req = 1'b1; inst_addr = 32'h0000_00C0; smp();
    cyc(); inst_req = 1'b0; smp();
    check("d_req1", {31'd0, mem_req}, 32'd1);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D; smp();
    cyc(); mem_ready = 1'b0; smp();
    check("d_ivalid3", {31'd0, inst_valid}, 32'd1);
    check("d_irdata3", inst_rdata, 32'h0BAD_F00D);

    // Ready arrives on the last allowed access cycle: no timeout.
    cyc(); data_req = 1'b1; data_addr = 32'h0000_0180; smp();
    for (int i = 1; i <= 16; i++) begin
      cyc(); mem_ready = (i == 16); mem_rdata = 32'hA5A5_A5A5; smp();
    end
    cyc(); mem_ready = 1'b0; smp();
    check("l_dvalid17", {31'd0, data_valid}, 32'd1);
    check("l_drdata17", data_rdata, 32'hA5A5_A5A5);
    check("l_err17", {31'd0, bus_err}, 32'd0);
    cyc(); data_req = 1'b0;

    // Reset in the middle of a waiting data read.
    cyc(); data_req = 1'b1; data_addr = 32'h0000_0300; smp();
    cyc(); smp();
    check("r_req1", {31'd0, mem_req}, 32'd1);
    cyc(); rst = 1'b1; smp();
    cyc(); rst = 1'b0; data_req = 1'b0; smp();
    check("r_req3", {31'd0, mem_req}, 32'd0);
    check("r_addr3", mem_addr, 32'd0);
    check("r_irdata3", inst_rdata, 32'd0);
    check("r_drdata3", data_rdata, 32'd0);
    check("r_dvalid3", {31'd0, data_valid}, 32'd0);
    cyc(); inst_req = 1'b1; inst_addr = 32'h0000_0044; smp();
    check("r_dvalid4", {31'd0, data_valid}, 32'd0);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'h1234_5678; smp();
    check("r_req5", {31'd0, mem_req}, 32'd1);
    check("r_addr5", mem_addr, 32'h0000_0044);
    cyc(); mem_ready = 1'b0; smp();
    check("r_ivalid6", {31'd0, inst_valid}, 32'd1);
    check("r_irdata6", inst_rdata, 32'h1234_5678);
    cyc(); inst_req = 1'b0;

    // Data read that never sees mem_ready: timeout.
    cyc(); data_req = 1'b1; data_addr = 32'h0000_0400; smp();
    for (int i = 1; i <= 16; i++) begin
      cyc(); smp();
      if (i == 16) check("t_err16", {31'd0, bus_err}, 32'd0);
    end
    cyc(); smp();
    check("t_err17", {31'd0, bus_err}, 32'd1);
    check("t_dvalid17", {31'd0, data_valid}, 32'd1);
    check("t_drdata17", data_rdata, 32'd0);
    cyc(); data_req = 1'b0;
    repeat (3) begin cyc(); smp(); end
    check("t_sticky", {31'd0, bus_err}, 32'd1);
    cyc(); inst_req = 1'b1; inst_addr = 32'h0000_0048; smp();
    cyc(); mem_ready = 1'b1; mem_rdata = 32'h7777_0000; smp();
    cyc(); mem_ready = 1'b0; inst_req = 1'b0; smp();
    check("t_sticky2", {31'd0, bus_err}, 32'd1);
    cyc(); rst = 1'b1; smp();
    cyc(); rst = 1'b0; smp();
    check("t_err_rst", {31'd0, bus_err}, 32'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of access-state cycles without mem_ready before an access is aborted.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 inst_req  input  1  SHALL be the fetch-stage request, held high with inst_addr stable until inst_valid.
REQ-005 inst_addr  input  32  SHALL be the fetch address.
REQ-006 data_req  input  1  SHALL be the memory-stage request, held high with data_addr/data_wr/data_wdata stable until data_valid.
REQ-007 data_wr  input  1  SHALL select write (1) or read (0) for the data request.
REQ-008 data_addr, data_wdata  input  32 each  SHALL be the data address and write data.
REQ-009 mem_rdata  input  32  SHALL be the read data from the shared single-port memory, valid when mem_ready=1.
REQ-010 mem_ready  input  1  SHALL be the memory completion strobe.
REQ-011 mem_req, mem_wr  output  1 each  SHALL be the memory request and write enable.
REQ-012 mem_addr, mem_wdata  output  32 each  SHALL be the memory address and write data.
REQ-013 inst_rdata, data_rdata  output  32 each  SHALL be the registered read results.
REQ-014 inst_valid, data_valid  output  1 each  SHALL be one-cycle completion pulses.
REQ-015 stall_if, stall_mem  output  1 each  SHALL be the pipeline stall requests.
REQ-016 bus_err  output  1  SHALL be a sticky timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, IACC, DACC, DONE.
REQ-018 IDLE: data_req=1 -> latch data addr/wr/wdata, go DACC; else inst_req=1 -> latch inst_addr, go IACC; else stay.
REQ-019 Both requests high in IDLE SHALL grant data first; instruction is granted on the first IDLE cycle after that completes.
REQ-020 In IACC/DACC mem_req SHALL be 1 and mem_addr/mem_wr/mem_wdata SHALL be driven from the latched values (mem_wr=0 in IACC); in IDLE/DONE mem_req=0, mem_wr=0.
REQ-021 Access state with mem_ready=1 -> register mem_rdata into inst_rdata (IACC) or data_rdata (DACC read only), go DONE.
REQ-022 A data write SHALL leave data_rdata unchanged.
REQ-023 A 5-bit wait counter SHALL clear on entering IACC/DACC and increment each access cycle without mem_ready.
REQ-024 Counter reaching TIMEOUT-1 with mem_ready=0 -> set bus_err, load 0 into the granted rdata register (reads), go DONE.
REQ-025 DONE SHALL assert inst_valid or data_valid (matching grant) for exactly one cycle, issue no grant, return to IDLE.
REQ-026 Latency: request sampled in IDLE at cycle 0, mem_ready at first access cycle (cycle 1) -> valid at cycle 2; each wait cycle adds one.
REQ-027 stall_if = inst_req & ~inst_valid; stall_mem = data_req & ~data_valid (combinational from registered state).
REQ-028 Requests dropped mid-access SHALL NOT abort the access; it completes and pulses valid.
REQ-029 bus_err SHALL remain 1 until reset.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, wait counter 0, all latched values 0, and all outputs (mem_req, mem_wr, mem_addr, mem_wdata, inst_rdata, data_rdata, valids, bus_err) to 0, including mid-access.
REQ-031 Release of rst SHALL allow a grant on the first following IDLE cycle.

Verification
REQ-032 inst_req, addr 0x00000040, mem_ready in cycle 1 with rdata 0x8C010004 -> mem_req high cycle 1, inst_valid and inst_rdata=0x8C010004 in cycle 2, stall_if high cycles 0-1.
REQ-033 inst_req and data_req (read 0x100) together -> DACC first; data_valid cycle 2; IACC entered cycle 4; inst_valid cycle 5 with ready immediate.
REQ-034 Data write 0x200, wdata 0xDEADBEEF, ready after 3 wait cycles -> mem_wr=1, mem_wdata=0xDEADBEEF cycles 1-4, data_valid cycle 5, data_rdata unchanged.
REQ-035 Read with mem_ready never asserted, TIMEOUT=16 -> bus_err=1 and data_valid with data_rdata=0 on cycle 17; bus_err stays 1.
REQ-036 rst asserted during DACC with wait pending -> next cycle mem_req=0, all outputs 0, no valid pulse; new request after release served normally.
